// File: rtl/gun_bullet.sv
// Single-shot bullet: launches from the gun muzzle on a fire press, climbs one
// STEP per movement tick, and reports a hit or a miss to the score logic.
module gun_bullet #(
  parameter int unsigned X_MIN    = 20,
  parameter int unsigned X_MAX    = 620,
  parameter int unsigned Y_START  = 440,
  parameter int unsigned Y_TOP    = 0,
  parameter int unsigned STEP     = 8,
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fire,
  input  logic [9:0] gunx,
  input  logic       hit_in,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic       hit_ack,
  output logic       miss,
  output logic [7:0] hits
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned POS_W = 10;

  typedef enum logic [1:0] {IDLE, FLY, HIT} state_t;

  state_t             state, state_d;
  logic               fire_q;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic               fire_rise;
  logic               y_low;
  logic [POS_W-1:0]   x_clamp;
  logic [POS_W-1:0]   x_d, y_d;
  logic               active_d, ack_d, miss_c;
  logic [7:0]         hits_d;

  assign tick      = (cnt == CNT_W'(TICK_DIV - 1));
  assign fire_rise = fire & ~fire_q;
  // 11-bit compare so the step subtraction can never wrap below the top row
  assign y_low     = ({1'b0, bullet_y} < 11'(Y_TOP + STEP));

  // Muzzle position limited to the legal bullet columns
  always_comb begin
    x_clamp = gunx;
    if (gunx > POS_W'(X_MAX)) begin
      x_clamp = POS_W'(X_MAX);
    end else if (gunx < POS_W'(X_MIN)) begin
      x_clamp = POS_W'(X_MIN);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d = state;
    x_d     = bullet_x;
    y_d     = bullet_y;
    hits_d  = hits;
    miss_c  = 1'b0;
    case (state)
      IDLE: begin
        if (fire_rise) begin
          x_d     = x_clamp;
          y_d     = POS_W'(Y_START);
          state_d = FLY;
        end
      end
      FLY: begin
        if (hit_in) begin
          state_d = HIT;
        end else if (tick && y_low) begin
          miss_c  = 1'b1;
          y_d     = POS_W'(Y_START);
          state_d = IDLE;
        end else if (tick) begin
          y_d = bullet_y - POS_W'(STEP);
        end
      end
      HIT: begin
        if (hits != 8'hFF) begin
          hits_d = hits + 8'd1;
        end
        y_d     = POS_W'(Y_START);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d == FLY);
    ack_d    = (state_d == HIT);
  end

  // The miss pulse must coincide with the FLY tick that ends the flight, so it
  // depends on the live hit_in and cannot be registered.
  assign miss = miss_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fire_q        <= 1'b1;
      cnt           <= '0;
      bullet_x      <= '0;
      bullet_y      <= POS_W'(Y_START);
      bullet_active <= 1'b0;
      hit_ack       <= 1'b0;
      hits          <= '0;
    end else begin
      state         <= state_d;
      fire_q        <= fire;
      cnt           <= tick ? '0 : cnt + CNT_W'(1);
      bullet_x      <= x_d;
      bullet_y      <= y_d;
      bullet_active <= active_d;
      hit_ack       <= ack_d;
      hits          <= hits_d;
    end
  end

endmodule

// File: tb/tb_gun_bullet.sv
// Directed bench for gun_bullet with a short movement tick (TICK_DIV=4).
module tb_gun_bullet;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fire;
  logic [9:0] gunx;
  logic       hit_in;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_active;
  logic       hit_ack;
  logic       miss;
  logic [7:0] hits;

  int checks = 0;
  int failures = 0;
  int ticks_seen = 0;
  int t0;
  logic [1:0] mcnt;
  logic tick_m;

  gun_bullet #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .fire(fire), .gunx(gunx), .hit_in(hit_in),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
    .hit_ack(hit_ack), .miss(miss), .hits(hits)
  );

  always #5 clk = ~clk;

  // Reference tick phase: a free-running 0..3 counter from reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 2'd0;
    else        mcnt <= mcnt + 2'd1;
  end
  assign tick_m = (mcnt == 2'd3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    if (tick_m) ticks_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic pass_ticks(input int n);
    int target;
    int guard;
    target = ticks_seen + n;
    guard = 0;
    while (ticks_seen < target && guard < 4 * n + 8) begin
      cyc();
      guard++;
    end
    if (ticks_seen < target) chk("pass_ticks_timeout", 32'(ticks_seen), 32'(target));
  endtask

  task automatic to_tick();
    int guard;
    guard = 0;
    while (!tick_m && guard < 8) begin
      cyc();
      guard++;
    end
    if (!tick_m) chk("to_tick_timeout", 32'(tick_m), 32'd1);
  endtask

  task automatic press();
    fire = 1'b1;
    cyc();
    fire = 1'b0;
  endtask

  task automatic hit_now();
    hit_in = 1'b1;
    cyc();
    hit_in = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fire = 1'b1; gunx = 10'd310; hit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(bullet_x), 32'd0);
    chk("rst_y", 32'(bullet_y), 32'd440);
    chk("rst_active", 32'(bullet_active), 32'd0);
    chk("rst_ack", 32'(hit_ack), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_hits", 32'(hits), 32'd0);

    // Fire held through reset release must not launch
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    chk("held_no_launch", 32'(bullet_active), 32'd0);
    fire = 1'b0;
    cyc();
    press();
    t0 = ticks_seen;
    chk("launch_active", 32'(bullet_active), 32'd1);
    chk("launch_x", 32'(bullet_x), 32'd310);
    chk("launch_y", 32'(bullet_y), 32'd440);

    // Full climb to the top row, then miss
    pass_ticks(10);
    chk("climb10_y", 32'(bullet_y), 32'd360);
    pass_ticks(45);
    chk("top_y", 32'(bullet_y), 32'd0);
    chk("top_active", 32'(bullet_active), 32'd1);
    to_tick();
    chk("miss_pulse", 32'(miss), 32'd1);
    chk("miss_no_ack", 32'(hit_ack), 32'd0);
    cyc();
    chk("miss_clear", 32'(miss), 32'd0);
    chk("miss_inactive", 32'(bullet_active), 32'd0);
    chk("miss_y_reload", 32'(bullet_y), 32'd440);
    chk("miss_hits", 32'(hits), 32'd0);
    chk("miss_x", 32'(bullet_x), 32'd310);

    // Hit after three ticks, asserted in a tick cycle
    gunx = 10'd200;
    press();
    pass_ticks(3);
    chk("pre_hit_y", 32'(bullet_y), 32'd416);
    to_tick();
    hit_in = 1'b1;
    #1;
    chk("hit_no_miss", 32'(miss), 32'd0);
    cyc();
    hit_in = 1'b0;
    chk("hit_ack", 32'(hit_ack), 32'd1);
    chk("hit_inactive", 32'(bullet_active), 32'd0);
    chk("hit_y_hold", 32'(bullet_y), 32'd416);
    cyc();
    chk("hit_ack_clear", 32'(hit_ack), 32'd0);
    chk("hit_count1", 32'(hits), 32'd1);
    chk("hit_y_reload", 32'(bullet_y), 32'd440);

    // Clamping and frozen x
    gunx = 10'd700;
    cyc();
    press();
    chk("clamp_high", 32'(bullet_x), 32'd620);
    gunx = 10'd5;
    pass_ticks(2);
    chk("x_frozen", 32'(bullet_x), 32'd620);
    hit_now();
    chk("hit_count2", 32'(hits), 32'd2);
    press();
    chk("clamp_low", 32'(bullet_x), 32'd20);
    hit_now();
    chk("hit_count3", 32'(hits), 32'd3);

    // Fire ignored in flight and on the miss cycle
    gunx = 10'd310;
    press();
    t0 = ticks_seen;
    pass_ticks(2);
    gunx = 10'd50;
    cyc();
    press();
    chk("refire_x", 32'(bullet_x), 32'd310);
    chk("refire_y", 32'(bullet_y), 32'(440 - 8 * (ticks_seen - t0)));
    chk("refire_active", 32'(bullet_active), 32'd1);
    pass_ticks(55 - (ticks_seen - t0));
    chk("refire_top_y", 32'(bullet_y), 32'd0);
    to_tick();
    fire = 1'b1;
    chk("miss2_pulse", 32'(miss), 32'd1);
    cyc();
    fire = 1'b0;
    chk("miss_fire_lost", 32'(bullet_active), 32'd0);
    cyc();
    chk("miss_fire_lost2", 32'(bullet_active), 32'd0);
    press();
    chk("relaunch", 32'(bullet_active), 32'd1);
    chk("relaunch_x", 32'(bullet_x), 32'd50);
    hit_now();
    chk("hit_count4", 32'(hits), 32'd4);

    // Saturation at 255
    for (int i = 0; i < 251; i++) begin
      press();
      hit_now();
    end
    chk("hits_255", 32'(hits), 32'd255);
    press();
    hit_in = 1'b1;
    cyc();
    hit_in = 1'b0;
    chk("sat_ack", 32'(hit_ack), 32'd1);
    cyc();
    chk("sat_hold", 32'(hits), 32'd255);

    // Asynchronous reset mid-flight
    press();
    pass_ticks(2);
    chk("pre_rst_active", 32'(bullet_active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_active", 32'(bullet_active), 32'd0);
    chk("arst_x", 32'(bullet_x), 32'd0);
    chk("arst_y", 32'(bullet_y), 32'd440);
    chk("arst_hits", 32'(hits), 32'd0);
    chk("arst_ack", 32'(hit_ack), 32'd0);
    chk("arst_miss", 32'(miss), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gun_bullet.md
Name: gun_bullet

Overview:
- Projectile block on the consuming side of the gun position interface: reads the gun's 10-bit horizontal position and a fire button.
- On a fire press it launches one bullet from the gun's muzzle and moves it upward at a fixed tick rate.
- It reports hit or miss and exports bullet coordinates to the VGA renderer and to the target collision logic.
- Sits between the gun block (gunx source) and the target/score logic (hit_in source, hit_ack and miss consumers).

Parameters:
- X_MIN, 20, lowest legal bullet x; latched gunx is clamped up to this.
- X_MAX, 620, highest legal bullet x; latched gunx is clamped down to this.
- Y_START, 440, bullet y at launch (muzzle row).
- Y_TOP, 0, topmost row a bullet may occupy.
- STEP, 8, rows moved per tick.
- TICK_DIV, 833333, clk cycles per movement tick (60 Hz at 50 MHz); must be at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fire  in  1  fire button level, already synchronised, active-high.
- gunx  in  10  current gun x position.
- hit_in  in  1  collision from target logic, level, sampled only in FLY.
- bullet_x  out  10  bullet x coordinate.
- bullet_y  out  10  bullet y coordinate.
- bullet_active  out  1  high while state is FLY; renderer draws the bullet only when high.
- hit_ack  out  1  one-cycle pulse when a hit is accepted.
- miss  out  1  one-cycle pulse when the bullet leaves the top of the field.
- hits  out  8  count of accepted hits, saturating at 255.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - bullet_x=0, bullet_y=Y_START, bullet_active=0, hit_ack=0, miss=0, hits=0.
  - Tick counter=0.
  - fire_q=1, so a button held through reset release does not fire.
  - Reset mid-flight aborts the shot immediately; no pulse is emitted.
- Edge detect: fire_q registers fire every cycle. fire_rise = fire & ~fire_q. Holding fire never auto-repeats.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1, independent of state.
  - tick is a one-cycle pulse in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- FSM states: IDLE, FLY, HIT.
  - IDLE:
    - On fire_rise: bullet_x <= clamp(gunx), bullet_y <= Y_START, next state FLY.
    - clamp: gunx>X_MAX gives X_MAX; gunx<X_MIN gives X_MIN; otherwise gunx.
    - Otherwise hold. Launch latency: bullet_active is high the cycle after fire_rise.
  - FLY (evaluated in priority order):
    - hit_in=1: next state HIT, regardless of tick.
    - Else on tick with bullet_y < Y_TOP+STEP: miss=1 for one cycle, bullet_y <= Y_START, next state IDLE.
    - Else on tick: bullet_y <= bullet_y - STEP.
    - Else hold.
    - bullet_x is frozen during flight; later gunx changes are ignored.
  - HIT (exactly one cycle):
    - hit_ack=1 that cycle; hits increments unless already 255.
    - bullet_active=0; bullet_y <= Y_START; next state IDLE.
- Arithmetic and widths:
  - Compare bullet_y against Y_TOP+STEP as an unsigned 11-bit value, so the subtraction never underflows.
  - bullet_y never drops below Y_TOP.
- Fire outside IDLE:
  - Ignored in FLY and HIT; no queuing.
  - A fire_rise in the same cycle as the FLY-to-IDLE or HIT-to-IDLE transition is lost. The press must be released and re-pressed.
- hit_ack and miss are mutually exclusive and never assert in IDLE.

Test Plan (bench uses TICK_DIV=4, other parameters at default):
1. Hold rst_n=0 with fire=1, release rst_n with fire still 1 -> no launch, bullet_active stays 0. Drop fire, raise it -> bullet_active=1 next cycle, bullet_x=gunx, bullet_y=440.
2. Launch with gunx=310, hit_in=0 -> bullet_y decrements by 8 per tick and reaches 0 after 55 ticks. On tick 56: miss pulses one cycle, bullet_active=0, bullet_y=440, hits=0.
3. Launch, wait 3 ticks (y=416), assert hit_in in a tick cycle -> state HIT: hit_ack pulses one cycle, hits=1, bullet_y not decremented. IDLE the cycle after.
4. Clamp: launch with gunx=700 -> bullet_x=620. Launch with gunx=5 -> bullet_x=20. Change gunx mid-flight -> bullet_x unchanged.
5. fire_rise during FLY -> ignored, no second launch. Single fire_rise coinciding with the miss cycle -> no launch. Next fire_rise in IDLE launches.
6. Force hits=255 via 255 hit sequences (or a preloaded sequence) and one more hit -> hits stays 255, hit_ack still pulses. Drop rst_n mid-flight -> all outputs at reset values immediately.
